// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the BCD timer: FSM encoding, digit type,
// lower-stage modulus and the preset-sanitising helper.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int LOW_MOD = 60;

  // A preset stage is usable only if both nibbles are decimal and the value fits the modulus
  function automatic logic stage_ok(input bcd_digit_t hi, input bcd_digit_t lo, input int modulus);
    int v;
    v = int'(hi) * 10 + int'(lo);
    return (hi <= 4'd9) && (lo <= 4'd9) && (v < modulus);
  endfunction

endpackage

// File: rtl/bcd_timer_stage.sv
// One two-digit BCD stage counting modulo MOD; carry/borrow ripples through
// i_cin/o_cout, and o_nxt_* exposes the value the stage takes on a step.
module bcd_mod_stage
  import bcd_timer_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_load,
  input  bcd_digit_t i_ld_hi,
  input  bcd_digit_t i_ld_lo,
  input  logic       i_step,
  input  logic       i_up,
  input  logic       i_cin,
  output bcd_digit_t o_hi,
  output bcd_digit_t o_lo,
  output bcd_digit_t o_nxt_hi,
  output bcd_digit_t o_nxt_lo,
  output logic       o_cout
);

  localparam bcd_digit_t LP_MAX_HI = 4'((MOD - 1) / 10);
  localparam bcd_digit_t LP_MAX_LO = 4'((MOD - 1) % 10);

  bcd_digit_t r_hi, r_lo;
  bcd_digit_t w_nxt_hi, w_nxt_lo;
  logic       w_at_max, w_at_zero;

  assign w_at_max  = (r_hi == LP_MAX_HI) && (r_lo == LP_MAX_LO);
  assign w_at_zero = (r_hi == 4'd0) && (r_lo == 4'd0);
  assign o_cout    = i_cin && (i_up ? w_at_max : w_at_zero);

  // Next stage value when this stage receives a carry/borrow
  always_comb begin
    w_nxt_hi = r_hi;
    w_nxt_lo = r_lo;
    if (i_cin) begin
      if (i_up) begin
        if (w_at_max) begin
          w_nxt_hi = 4'd0;
          w_nxt_lo = 4'd0;
        end else if (r_lo == 4'd9) begin
          w_nxt_hi = r_hi + 4'd1;
          w_nxt_lo = 4'd0;
        end else begin
          w_nxt_lo = r_lo + 4'd1;
        end
      end else begin
        if (w_at_zero) begin
          w_nxt_hi = LP_MAX_HI;
          w_nxt_lo = LP_MAX_LO;
        end else if (r_lo == 4'd0) begin
          w_nxt_hi = r_hi - 4'd1;
          w_nxt_lo = 4'd9;
        end else begin
          w_nxt_lo = r_lo - 4'd1;
        end
      end
    end else begin
      w_nxt_hi = r_hi;
      w_nxt_lo = r_lo;
    end
  end

  // Digit registers: clear over load over step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= 4'd0;
      r_lo <= 4'd0;
    end else if (i_clear) begin
      r_hi <= 4'd0;
      r_lo <= 4'd0;
    end else if (i_load) begin
      if (stage_ok(i_ld_hi, i_ld_lo, MOD)) begin
        r_hi <= i_ld_hi;
        r_lo <= i_ld_lo;
      end else begin
        r_hi <= 4'd0;
        r_lo <= 4'd0;
      end
    end else if (i_step) begin
      r_hi <= w_nxt_hi;
      r_lo <= w_nxt_lo;
    end
  end

  assign o_hi     = r_hi;
  assign o_lo     = r_lo;
  assign o_nxt_hi = w_nxt_hi;
  assign o_nxt_lo = w_nxt_lo;

endmodule

// File: rtl/bcd_timer.sv
// Multi-stage BCD up/down timer with prescaler and IDLE/RUN/HOLD control.
// Optional sticky alarm compare is compiled in with BCD_TIMER_ALARM_EN.
module bcd_timer
  import bcd_timer_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int TOP_MOD    = 60,
  parameter int TICK_DIV   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    up,
  input  logic                    load,
  input  logic [8*NUM_STAGES-1:0] load_val,
  output logic [8*NUM_STAGES-1:0] count,
  output logic                    running,
`ifdef BCD_TIMER_ALARM_EN
  output logic                    tc,
  input  logic [8*NUM_STAGES-1:0] alarm_val,
  output logic                    alarm
`else
  output logic                    tc
`endif
);

  localparam int          LP_W    = 8 * NUM_STAGES;
  localparam logic [15:0] LP_LAST = 16'(TICK_DIV - 1);

  state_t            r_state;
  logic [15:0]       r_presc;
  logic              r_running, r_tc;
  logic [NUM_STAGES:0] w_carry;
  logic [LP_W-1:0]   w_nxt_count;
  logic w_cmd, w_cnt_zero, w_nxt_zero, w_down_zero, w_tick, w_step, w_stall, w_start_ok, w_tc;

  assign w_carry[0]  = 1'b1;
  assign w_cmd       = clear | load | stop | start;
  assign w_cnt_zero  = (count == {LP_W{1'b0}});
  assign w_nxt_zero  = (w_nxt_count == {LP_W{1'b0}});
  // Counting down from zero is never a step: the timer parks in IDLE instead
  assign w_down_zero = !up && w_cnt_zero;
  assign w_tick      = (r_state == ST_RUN) && (r_presc == LP_LAST);
  assign w_step      = w_tick && !w_cmd && !w_down_zero;
  assign w_stall     = w_tick && !w_cmd && w_down_zero;
  assign w_start_ok  = start && !stop && !w_down_zero;
  assign w_tc        = w_step && (up ? w_carry[NUM_STAGES] : w_nxt_zero);

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    localparam int LP_MOD = (g == NUM_STAGES - 1) ? TOP_MOD : LOW_MOD;
    bcd_mod_stage #(.MOD(LP_MOD)) u_stage (
      .clk      (clk),
      .reset    (reset),
      .i_clear  (clear),
      .i_load   (load),
      .i_ld_hi  (load_val[8*g+4 +: 4]),
      .i_ld_lo  (load_val[8*g +: 4]),
      .i_step   (w_step),
      .i_up     (up),
      .i_cin    (w_carry[g]),
      .o_hi     (count[8*g+4 +: 4]),
      .o_lo     (count[8*g +: 4]),
      .o_nxt_hi (w_nxt_count[8*g+4 +: 4]),
      .o_nxt_lo (w_nxt_count[8*g +: 4]),
      .o_cout   (w_carry[g+1])
    );
  end

`ifdef BCD_TIMER_ALARM_EN
  logic r_alarm;
`endif

  // Control FSM, prescaler and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_presc   <= 16'd0;
      r_running <= 1'b0;
      r_tc      <= 1'b0;
`ifdef BCD_TIMER_ALARM_EN
      r_alarm   <= 1'b0;
`endif
    end else begin
      r_tc <= w_tc;
`ifdef BCD_TIMER_ALARM_EN
      if (clear) r_alarm <= 1'b0;
      else if (w_step && (w_nxt_count == alarm_val)) r_alarm <= 1'b1;
`endif
      if (clear) begin
        r_state   <= ST_IDLE;
        r_presc   <= 16'd0;
        r_running <= 1'b0;
      end else begin
        if (load || start) r_presc <= 16'd0;
        else if (r_state == ST_RUN) r_presc <= (r_presc == LP_LAST) ? 16'd0 : r_presc + 16'd1;
        case (r_state)
          ST_IDLE, ST_HOLD: begin
            if (w_start_ok) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end
          end
          ST_RUN: begin
            if (stop) begin
              r_state   <= ST_HOLD;
              r_running <= 1'b0;
            end else if ((w_step && !up && w_nxt_zero) || w_stall) begin
              r_state   <= ST_IDLE;
              r_running <= 1'b0;
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign running = r_running;
  assign tc      = r_tc;
`ifdef BCD_TIMER_ALARM_EN
  assign alarm   = r_alarm;
`endif

endmodule

// File: tb/tb_bcd_timer.sv
// Directed self-checking bench for bcd_timer: one DUT with TICK_DIV=1 and one
// with TICK_DIV=4 share stimulus; inputs change and outputs are sampled on negedge.
module tb_bcd_timer;

  logic        clk = 1'b0;
  logic        reset, start, stop, clear, up, load;
  logic [15:0] load_val;
  logic [15:0] count1, count4;
  logic        running1, running4, tc1, tc4;
  int          errors = 0;
  int          checks = 0;
`ifdef BCD_TIMER_ALARM_EN
  logic [15:0] alarm_val;
  logic        alarm1, alarm4;
`endif

  always #5 clk = ~clk;

  bcd_timer #(.NUM_STAGES(2), .TOP_MOD(60), .TICK_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .up(up),
    .load(load), .load_val(load_val), .count(count1), .running(running1),
`ifdef BCD_TIMER_ALARM_EN
    .tc(tc1), .alarm_val(alarm_val), .alarm(alarm1)
`else
    .tc(tc1)
`endif
  );

  bcd_timer #(.NUM_STAGES(2), .TOP_MOD(60), .TICK_DIV(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .up(up),
    .load(load), .load_val(load_val), .count(count4), .running(running4),
`ifdef BCD_TIMER_ALARM_EN
    .tc(tc4), .alarm_val(alarm_val), .alarm(alarm4)
`else
    .tc(tc4)
`endif
  );

  // Command helpers: called just after a negedge, they span exactly one rising edge
  task automatic cmd_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask
  task automatic cmd_stop();
    stop = 1'b1; @(negedge clk); stop = 1'b0;
  endtask
  task automatic cmd_clear();
    clear = 1'b1; @(negedge clk); clear = 1'b0;
  endtask
  task automatic cmd_load(input logic [15:0] v);
    load = 1'b1; load_val = v; @(negedge clk); load = 1'b0;
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; up = 1'b1; load = 1'b0; load_val = 16'h0000;
`ifdef BCD_TIMER_ALARM_EN
    alarm_val = 16'h0010;
`endif
    tick(2);
    checks++; if (count1 !== 16'h0000) begin errors++; $display("FAIL reset_count got=%h exp=0000", count1); end
    checks++; if (running1 !== 1'b0) begin errors++; $display("FAIL reset_running got=%b exp=0", running1); end
    checks++; if (tc1 !== 1'b0) begin errors++; $display("FAIL reset_tc got=%b exp=0", tc1); end
    checks++; if (count4 !== 16'h0000) begin errors++; $display("FAIL reset_count4 got=%h exp=0000", count4); end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_up_wrap();
    up = 1'b1;
    cmd_clear();
    cmd_load(16'h5959);
    cmd_start();
    checks++; if (count1 !== 16'h5959) begin errors++; $display("FAIL upwrap_pre got=%h exp=5959", count1); end
    checks++; if (running1 !== 1'b1) begin errors++; $display("FAIL upwrap_run got=%b exp=1", running1); end
    tick(1);
    checks++; if (count1 !== 16'h0000) begin errors++; $display("FAIL upwrap_count got=%h exp=0000", count1); end
    checks++; if (tc1 !== 1'b1) begin errors++; $display("FAIL upwrap_tc got=%b exp=1", tc1); end
    checks++; if (running1 !== 1'b1) begin errors++; $display("FAIL upwrap_running got=%b exp=1", running1); end
    tick(1);
    checks++; if (count1 !== 16'h0001) begin errors++; $display("FAIL upwrap_next got=%h exp=0001", count1); end
    checks++; if (tc1 !== 1'b0) begin errors++; $display("FAIL upwrap_tc_once got=%b exp=0", tc1); end
    cmd_stop();
  endtask

  task automatic test_down_terminal();
    cmd_clear();
    up = 1'b0;
    cmd_load(16'h0003);
    cmd_start();
    checks++; if (count1 !== 16'h0003) begin errors++; $display("FAIL down_pre got=%h exp=0003", count1); end
    tick(1);
    checks++; if (count1 !== 16'h0002) begin errors++; $display("FAIL down_2 got=%h exp=0002", count1); end
    tick(1);
    checks++; if (count1 !== 16'h0001) begin errors++; $display("FAIL down_1 got=%h exp=0001", count1); end
    tick(1);
    checks++; if (count1 !== 16'h0000) begin errors++; $display("FAIL down_0 got=%h exp=0000", count1); end
    checks++; if (tc1 !== 1'b1) begin errors++; $display("FAIL down_tc got=%b exp=1", tc1); end
    checks++; if (running1 !== 1'b0) begin errors++; $display("FAIL down_running got=%b exp=0", running1); end
    tick(3);
    checks++; if (count1 !== 16'h0000 || tc1 !== 1'b0) begin errors++; $display("FAIL down_hold got=%h/%b exp=0000/0", count1, tc1); end
    cmd_start();
    tick(2);
    checks++; if (running1 !== 1'b0 || count1 !== 16'h0000) begin errors++; $display("FAIL down_start_ignored got=%b/%h exp=0/0000", running1, count1); end
    cmd_load(16'h0100);
    cmd_start();
    tick(1);
    checks++; if (count1 !== 16'h0059) begin errors++; $display("FAIL down_borrow got=%h exp=0059", count1); end
    cmd_stop();
  endtask

  task automatic test_prescale_pause();
    up = 1'b1;
    cmd_clear();
    cmd_start();
    tick(3);
    checks++; if (count4 !== 16'h0000) begin errors++; $display("FAIL pre_early got=%h exp=0000", count4); end
    tick(1);
    checks++; if (count4 !== 16'h0001) begin errors++; $display("FAIL pre_first got=%h exp=0001", count4); end
    tick(64);
    checks++; if (count4 !== 16'h0017) begin errors++; $display("FAIL pre_17 got=%h exp=0017", count4); end
    cmd_stop();
    tick(20);
    checks++; if (count4 !== 16'h0017) begin errors++; $display("FAIL pause_hold got=%h exp=0017", count4); end
    checks++; if (running4 !== 1'b0) begin errors++; $display("FAIL pause_running got=%b exp=0", running4); end
    cmd_start();
    tick(3);
    checks++; if (count4 !== 16'h0017) begin errors++; $display("FAIL resume_early got=%h exp=0017", count4); end
    tick(1);
    checks++; if (count4 !== 16'h0018) begin errors++; $display("FAIL resume_step got=%h exp=0018", count4); end
    cmd_stop();
  endtask

  task automatic test_load_sanitise();
    cmd_clear();
    cmd_load(16'h7A42);
    checks++; if (count1 !== 16'h0042) begin errors++; $display("FAIL load_7a42 got=%h exp=0042", count1); end
    cmd_load(16'h1963);
    checks++; if (count1 !== 16'h1900) begin errors++; $display("FAIL load_1963 got=%h exp=1900", count1); end
    checks++; if (running1 !== 1'b0) begin errors++; $display("FAIL load_idle_state got=%b exp=0", running1); end
    up = 1'b1;
    cmd_start();
    cmd_load(16'h3000);
    checks++; if (count1 !== 16'h3000 || running1 !== 1'b1) begin errors++; $display("FAIL load_in_run got=%h/%b exp=3000/1", count1, running1); end
    tick(1);
    checks++; if (count1 !== 16'h3001) begin errors++; $display("FAIL load_then_step got=%h exp=3001", count1); end
  endtask

  task automatic test_priority_reset();
    up = 1'b1;
    clear = 1'b1; load = 1'b1; load_val = 16'h1234; start = 1'b1;
    @(negedge clk);
    clear = 1'b0; load = 1'b0; start = 1'b0;
    checks++; if (count1 !== 16'h0000 || running1 !== 1'b0) begin errors++; $display("FAIL prio got=%h/%b exp=0000/0", count1, running1); end
    cmd_start();
    tick(5);
    checks++; if (count1 !== 16'h0005) begin errors++; $display("FAIL prerst_count got=%h exp=0005", count1); end
    #2 reset = 1'b1;
    #1;
    checks++; if (count1 !== 16'h0000 || running1 !== 1'b0) begin errors++; $display("FAIL async_reset got=%h/%b exp=0000/0", count1, running1); end
    #1 reset = 1'b0;
    tick(4);
    checks++; if (count1 !== 16'h0000 || running1 !== 1'b0) begin errors++; $display("FAIL post_reset_idle got=%h/%b exp=0000/0", count1, running1); end
  endtask

`ifdef BCD_TIMER_ALARM_EN
  task automatic test_alarm();
    up = 1'b1;
    alarm_val = 16'h0010;
    cmd_clear();
    cmd_start();
    tick(9);
    checks++; if (count1 !== 16'h0009 || alarm1 !== 1'b0) begin errors++; $display("FAIL alarm_before got=%h/%b exp=0009/0", count1, alarm1); end
    tick(1);
    checks++; if (count1 !== 16'h0010 || alarm1 !== 1'b1) begin errors++; $display("FAIL alarm_rise got=%h/%b exp=0010/1", count1, alarm1); end
    tick(2);
    checks++; if (count1 !== 16'h0012 || alarm1 !== 1'b1) begin errors++; $display("FAIL alarm_sticky got=%h/%b exp=0012/1", count1, alarm1); end
    cmd_clear();
    checks++; if (alarm1 !== 1'b0) begin errors++; $display("FAIL alarm_clear got=%b exp=0", alarm1); end
  endtask
`endif

  initial begin
    test_reset();
    test_up_wrap();
    test_down_terminal();
    test_prescale_pause();
    test_load_sanitise();
    test_priority_reset();
`ifdef BCD_TIMER_ALARM_EN
    test_alarm();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
